dmem_responder: RTL and testbench

- Data-memory responder that sits behind the memory stage and services its load/store requests over a valid/ready request channel and a valid/ready response channel.
- Byte-addressable array of MEM_SIZE bytes. Accesses are 64-bit little-endian quadwords.
- Fixed, parameterised access latency, so the memory stage can be run against realistic multi-cycle memory.
- Out-of-range accesses are reported through an error flag, which feeds the status/exception logic.

---
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Quadword load/store responder over valid/ready channels with fixed access latency.
// Optional `DMEM_ALIGN_CHECK_EN also flags addresses with addr[2:0] != 0 as errors.
module dmem_responder #(
    parameter int unsigned MEM_SIZE = 512,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_error,
    output logic              busy
);

    localparam int unsigned       IDX_W    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int unsigned       CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_OK  = ADDR_W'(MEM_SIZE - 8);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [7:0]       mem_q [MEM_SIZE];
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;
    logic [63:0]      wdata_q;
    logic             err_d;
    logic [63:0]      rdata_d;

    // Compare the start address only, so addr+7 can never wrap into a false pass.
    always_comb begin
        err_d = (req_addr > LAST_OK);
`ifdef DMEM_ALIGN_CHECK_EN
        if (req_addr[2:0] != 3'b000) begin
            err_d = 1'b1;
        end
`endif
    end

    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rdata_d[8*i +: 8] = mem_q[idx_q + IDX_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            busy       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        idx_q     <= req_addr[IDX_W-1:0];
                        wdata_q   <= req_wdata;
                        err_q     <= err_d;
                        cnt_q     <= CNT_LOAD;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        if (we_q && !err_q) begin
                            for (int unsigned i = 0; i < 8; i++) begin
                                mem_q[idx_q + IDX_W'(i)] <= wdata_q[8*i +: 8];
                            end
                        end
                        resp_rdata <= (we_q || err_q) ? '0 : rdata_d;
                        resp_error <= err_q;
                        resp_valid <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a default instance (512 B, latency 2) and a small one (64 B, latency 1)
// checked against constant vectors and a byte-array reference model.
module tb_dmem_responder;

    localparam int unsigned SZ0  = 512;
    localparam int unsigned SZ1  = 64;
    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_error, busy;
    logic [1:0][63:0] req_addr, req_wdata, resp_rdata;

    int checks = 0;
    int errors = 0;

    byte unsigned mm0 [SZ0];
    byte unsigned mm1 [SZ1];

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    dmem_responder #(.MEM_SIZE(SZ0), .LATENCY(LAT0), .ADDR_W(64)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .busy(busy[0])
    );

    dmem_responder #(.MEM_SIZE(SZ1), .LATENCY(LAT1), .ADDR_W(64)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the access either errors as a whole or touches bytes addr..addr+7.
    function automatic void model(input int s, input bit we, input logic [63:0] addr,
                                  input logic [63:0] wd, output logic [63:0] rd, output logic err);
        longint unsigned lim = (s == 0) ? longint'(SZ0 - 8) : longint'(SZ1 - 8);
        err = (addr > lim);
`ifdef DMEM_ALIGN_CHECK_EN
        err = err | (addr[2:0] != 3'b000);
`endif
        rd = '0;
        if (!err) begin
            for (int i = 0; i < 8; i++) begin
                int a = int'(addr[15:0]) + i;
                if (s == 0) begin
                    if (we) mm0[a] = wd[8*i +: 8];
                    else    rd[8*i +: 8] = mm0[a];
                end else begin
                    if (we) mm1[a] = wd[8*i +: 8];
                    else    rd[8*i +: 8] = mm1[a];
                end
            end
        end
    endfunction

    // Entered and left #1 after a rising edge; completes the response handshake if resp_ready is high.
    task automatic txn(input int s, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic err, output int lat);
        int guard = 0;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        req_valid[s] = 1'b1;
        while (!req_ready[s] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid[s] && lat < 50);
        rd  = resp_rdata[s];
        err = resp_error[s];
        if (resp_ready[s]) begin
            @(posedge clk); #1;
            chk("resp_valid_clears", 64'(resp_valid[s]), 64'd0);
        end
    endtask

    task automatic run_checked(input int s, input string tag, input bit we,
                               input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] rd, mrd;
        logic        err, merr;
        int          lat;
        txn(s, we, addr, wd, rd, err, lat);
        model(s, we, addr, wd, mrd, merr);
        chk({tag, "_rdata"}, rd, mrd);
        chk({tag, "_error"}, 64'(err), 64'(merr));
        chk({tag, "_latency"}, 64'(lat), (s == 0) ? 64'(LAT0) : 64'(LAT1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, mrd, addr;
        logic        err, merr;
        int          lat;

        tbl[0]  = '{1'b1, 64'd0,   64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0};
        tbl[1]  = '{1'b0, 64'd0,   64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[2]  = '{1'b1, 64'd3,   64'hCAFEBABECAFEBABE, 64'h0, 1'b1};
        tbl[3]  = '{1'b1, 64'd3,   64'hDEADDEADDEADDEAD, 64'h0, 1'b1};
        tbl[4]  = '{1'b0, 64'd3,   64'h0, 64'h0, 1'b1};
        tbl[5]  = '{1'b0, 64'd0,   64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b0};
`else
        tbl[2]  = '{1'b1, 64'd3,   64'hCAFEBABECAFEBABE, 64'h0, 1'b0};
        tbl[3]  = '{1'b1, 64'd3,   64'hDEADDEADDEADDEAD, 64'h0, 1'b0};
        tbl[4]  = '{1'b0, 64'd3,   64'h0, 64'hDEADDEADDEADDEAD, 1'b0};
        tbl[5]  = '{1'b0, 64'd0,   64'h0, 64'hADDEADDEADA5A5A5, 1'b0};
`endif
        tbl[6]  = '{1'b1, 64'd504, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        tbl[7]  = '{1'b0, 64'd504, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        tbl[8]  = '{1'b1, 64'd505, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
        tbl[9]  = '{1'b0, 64'd504, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        tbl[10] = '{1'b0, 64'd512, 64'h0, 64'h0, 1'b1};
        tbl[11] = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1};
        tbl[12] = '{1'b0, 64'd505, 64'h0, 64'h0, 1'b1};
        tbl[13] = '{1'b1, 64'hFFFFFFFFFFFFFFF9, 64'h1111111111111111, 64'h0, 1'b1};
        tbl[14] = tbl[5];

        reset      = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_req_ready", 64'(req_ready[s]), 64'd1);
            chk("reset_resp_valid", 64'(resp_valid[s]), 64'd0);
            chk("reset_rdata", resp_rdata[s], 64'd0);
            chk("reset_error", 64'(resp_error[s]), 64'd0);
            chk("reset_busy", 64'(busy[s]), 64'd0);
        end
        reset = 1'b0;

        // Give every byte a known value so later reads are predictable.
        for (int k = 0; k < int'(SZ0 / 8); k++) begin
            logic [63:0] d = {$urandom, $urandom};
            txn(0, 1'b1, 64'(8 * k), d, rd, err, lat);
            model(0, 1'b1, 64'(8 * k), d, mrd, merr);
        end
        for (int k = 0; k < int'(SZ1 / 8); k++) begin
            logic [63:0] d = {$urandom, $urandom};
            txn(1, 1'b1, 64'(8 * k), d, rd, err, lat);
            model(1, 1'b1, 64'(8 * k), d, mrd, merr);
        end

        foreach (tbl[i]) begin
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wd, rd, err, lat);
            model(0, tbl[i].we, tbl[i].addr, tbl[i].wd, mrd, merr);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_error", i), 64'(err), 64'(tbl[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT0));
        end

        // Backpressure: response held 5 cycles, a stray request pulse must be ignored.
        resp_ready[0] = 1'b0;
        txn(0, 1'b0, 64'd504, 64'h0, rd, err, lat);
        chk("bp_first_rdata", rd, 64'h0123456789ABCDEF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b1;
                req_addr[0]  = 64'd0;
                req_wdata[0] = 64'hFFFFFFFFFFFFFFFF;
            end
            if (k == 2) req_valid[0] = 1'b0;
            chk("bp_resp_valid", 64'(resp_valid[0]), 64'd1);
            chk("bp_rdata", resp_rdata[0], 64'h0123456789ABCDEF);
            chk("bp_error", 64'(resp_error[0]), 64'd0);
            chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(resp_valid[0]), 64'd0);
        chk("bp_release_ready", 64'(req_ready[0]), 64'd1);
        chk("bp_release_busy", 64'(busy[0]), 64'd0);
        run_checked(0, "bp_after_read0", 1'b0, 64'd0, 64'h0);

        // Reset while BUSY on a write: nothing committed, no response.
        req_we[0]    = 1'b1;
        req_addr[0]  = 64'd16;
        req_wdata[0] = 64'h1;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("rst_busy_before", 64'(busy[0]), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_no_resp", 64'(resp_valid[0]), 64'd0);
        end
        run_checked(0, "rst_read16", 1'b0, 64'd16, 64'h0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: addr = 64'($urandom_range(0, SZ0 - 1));
                6:                addr = 64'($urandom_range(SZ0 - 8, SZ0));
                7:                addr = {$urandom, $urandom};
                8:                addr = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
                default:          addr = 64'(8 * $urandom_range(0, SZ0 / 8 - 1));
            endcase
            run_checked(0, "rand", 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
        end

        run_checked(1, "l1_read8", 1'b0, 64'd8, 64'h0);
        run_checked(1, "l1_write9", 1'b1, 64'd9, 64'h1122334455667788);
        run_checked(1, "l1_read8_after", 1'b0, 64'd8, 64'h0);
        run_checked(1, "l1_read16", 1'b0, 64'd16, 64'h0);
        run_checked(1, "l1_read_last", 1'b0, 64'(SZ1 - 8), 64'h0);
        run_checked(1, "l1_read_over", 1'b0, 64'(SZ1 - 7), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
